// File: rtl/vector_pkg.sv
// Shared definitions for the vector writeback path: default geometry, beat
// count, collector state encoding and the lane/vector slice types used by execute.
package vector_pkg;

  localparam int N     = 32;
  localparam int V     = 20;
  localparam int L     = 4;
  localparam int A     = 5;
  localparam int BEATS = V / L;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

  typedef logic [N-1:0]   elem_t;
  typedef elem_t [L-1:0]  lane_slice_t;
  typedef elem_t [V-1:0]  vector_t;

endpackage

// File: rtl/vector_writeback_collector.sv
// Reassembles in-order L-lane execute beats into a V-element vector and offers
// one register-file write per vector, stalling execute until it is taken.
module vector_writeback_collector #(
  parameter int  N     = vector_pkg::N,
  parameter int  V     = vector_pkg::V,
  parameter int  L     = vector_pkg::L,
  parameter int  A     = vector_pkg::A,
  localparam int NUM_BEATS = V / L,
  localparam int CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  beat_valid_i,
  output logic                  beat_ready_o,
  input  logic [CNT_W-1:0]      beat_idx_i,
  input  logic [L-1:0][N-1:0]   beat_data_i,
  input  logic [A-1:0]          dest_addr_i,
  input  logic                  reg_write_i,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [A-1:0]          wb_addr_o,
  output logic                  wb_we_o,
  output logic [V-1:0][N-1:0]   wb_data_o,
  output logic                  busy_o,
  output logic                  seq_err_o
);

  import vector_pkg::*;

  generate
    if (V % L != 0) begin : g_bad_geometry
      $error("vector_writeback_collector: V must be a multiple of L");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [V*N-1:0]     vec_buf;
  logic               accept;
  logic               in_seq;
  logic               take;

  assign accept = beat_valid_i && beat_ready_o;
  // cnt is held at zero in IDLE, so the expected index is cnt in both collecting states.
  assign in_seq = (state == IDLE) ? (beat_idx_i == '0) : (beat_idx_i == cnt);
  assign take   = accept && in_seq;

  assign wb_data_o = vec_buf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = (NUM_BEATS == 1) ? WRITE : COLLECT;
      COLLECT: if (take && (cnt == LAST_BEAT)) state_nxt = WRITE;
      WRITE:   if (wb_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs: nothing here looks at beat_valid_i or wb_ready_i.
  always_comb begin
    beat_ready_o = 1'b1;
    busy_o       = 1'b0;
    wb_valid_o   = 1'b0;
    case (state)
      IDLE:    ;
      COLLECT: busy_o = 1'b1;
      WRITE: begin
        beat_ready_o = 1'b0;
        busy_o       = 1'b1;
        wb_valid_o   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      seq_err_o <= 1'b0;
      wb_addr_o <= '0;
      wb_we_o   <= 1'b0;
      vec_buf   <= '0;
    end else begin
      seq_err_o <= accept && !in_seq;
      if (take) begin
        vec_buf[int'(cnt)*L*N +: L*N] <= beat_data_i;
        cnt <= cnt + CNT_W'(1);
        if (state == IDLE) begin
          wb_addr_o <= dest_addr_i;
          wb_we_o   <= reg_write_i;
        end
      end else if ((state == WRITE) && wb_ready_i) begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vector_writeback_collector.sv
// Directed bench for the writeback collector: in-order collection, stalled
// writeback, out-of-sequence beats, reset mid-vector and a non-writing vector.
module tb_vector_writeback_collector;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              beat_valid;
  logic              beat_ready;
  logic [2:0]        beat_idx;
  logic [3:0][31:0]  beat_data;
  logic [4:0]        dest_addr;
  logic              reg_write;
  logic              wb_valid;
  logic              wb_ready;
  logic [4:0]        wb_addr;
  logic              wb_we;
  logic [19:0][31:0] wb_data;
  logic              busy;
  logic              seq_err;

  int checks = 0;
  int errors = 0;
  logic [639:0] snap;
  int valid_seen;

  vector_writeback_collector dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .beat_valid_i (beat_valid),
    .beat_ready_o (beat_ready),
    .beat_idx_i   (beat_idx),
    .beat_data_i  (beat_data),
    .dest_addr_i  (dest_addr),
    .reg_write_i  (reg_write),
    .wb_valid_o   (wb_valid),
    .wb_ready_i   (wb_ready),
    .wb_addr_o    (wb_addr),
    .wb_we_o      (wb_we),
    .wb_data_o    (wb_data),
    .busy_o       (busy),
    .seq_err_o    (seq_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lane i of beat k carries base + 4k + i, so element j of the vector is base + j.
  task automatic set_beat(input int k, input int base, input logic [4:0] dest, input logic we);
    beat_valid = 1'b1;
    beat_idx   = 3'(k);
    dest_addr  = dest;
    reg_write  = we;
    for (int i = 0; i < 4; i++) beat_data[i] = 32'(base + 4 * k + i);
  endtask

  function automatic logic [639:0] mk_vec(input int base);
    logic [639:0] v;
    for (int j = 0; j < 20; j++) v[j*32 +: 32] = 32'(base + j);
    return v;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wb_valid"},   wb_valid,   1'b0);
    chk({tag, "_wb_we"},      wb_we,      1'b0);
    chk({tag, "_wb_addr"},    wb_addr,    5'd0);
    chk({tag, "_wb_data"},    wb_data,    640'd0);
    chk({tag, "_seq_err"},    seq_err,    1'b0);
    chk({tag, "_busy"},       busy,       1'b0);
    chk({tag, "_beat_ready"}, beat_ready, 1'b1);
  endtask

  initial begin
    rst_n      = 1'b0;
    beat_valid = 1'b0;
    beat_idx   = '0;
    beat_data  = '0;
    dest_addr  = '0;
    reg_write  = 1'b0;
    wb_ready   = 1'b1;
    #12;
    chk_reset_outputs("por");
    tick();
    rst_n = 1'b1;
    tick();

    // In-order vector, register file always ready.
    for (int k = 0; k < 5; k++) begin
      set_beat(k, 0, 5'd7, 1'b1);
      tick();
      if (k == 0) chk("t1_busy_after_b0", busy, 1'b1);
      if (k == 3) chk("t1_no_valid_before_last", wb_valid, 1'b0);
    end
    beat_valid = 1'b0;
    chk("t1_wb_valid", wb_valid, 1'b1);
    chk("t1_ready_low", beat_ready, 1'b0);
    chk("t1_data", wb_data, mk_vec(0));
    chk("t1_addr", wb_addr, 5'd7);
    chk("t1_we", wb_we, 1'b1);
    tick();
    chk("t1_valid_drop", wb_valid, 1'b0);
    chk("t1_idle", busy, 1'b0);

    // Same stream with the register file stalling for 6 cycles.
    wb_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_beat(k, 0, 5'd7, 1'b1);
      tick();
    end
    chk("t2_wb_valid", wb_valid, 1'b1);
    snap = wb_data;
    chk("t2_data", snap, mk_vec(0));
    set_beat(0, 300, 5'd5, 1'b1);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("t2_hold_valid", wb_valid, 1'b1);
      chk("t2_hold_ready", beat_ready, 1'b0);
      chk("t2_hold_data", wb_data, snap);
      chk("t2_hold_addr", wb_addr, 5'd7);
    end
    wb_ready = 1'b1;
    tick();
    chk("t2_hs_valid", wb_valid, 1'b0);
    chk("t2_hs_not_taken", busy, 1'b0);
    chk("t2_hs_ready", beat_ready, 1'b1);
    tick();
    chk("t2_next_b0_taken", busy, 1'b1);
    chk("t2_next_addr", wb_addr, 5'd5);

    // Reset after beat 2 of the pending vector.
    for (int k = 1; k < 3; k++) begin
      set_beat(k, 300, 5'd5, 1'b1);
      tick();
    end
    beat_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      set_beat(k, 100, 5'd3, 1'b1);
      tick();
    end
    beat_valid = 1'b0;
    chk("rst_vec_valid", wb_valid, 1'b1);
    chk("rst_vec_addr", wb_addr, 5'd3);
    chk("rst_vec_data", wb_data, mk_vec(100));
    tick();
    valid_seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (wb_valid) valid_seen++;
      tick();
    end
    chk("rst_vec_single_write", valid_seen, 0);

    // Beats 0,1,3,2,3,4: the early 3 is dropped and flagged once.
    set_beat(0, 0, 5'd7, 1'b1);
    tick();
    chk("t3_err_b0", seq_err, 1'b0);
    set_beat(1, 0, 5'd7, 1'b1);
    tick();
    chk("t3_err_b1", seq_err, 1'b0);
    set_beat(3, 500, 5'd7, 1'b1);
    tick();
    chk("t3_err_pulse", seq_err, 1'b1);
    chk("t3_still_busy", busy, 1'b1);
    chk("t3_ready_kept", beat_ready, 1'b1);
    for (int k = 2; k < 5; k++) begin
      set_beat(k, 0, 5'd7, 1'b1);
      tick();
      chk("t3_err_clear", seq_err, 1'b0);
      if (k < 4) chk("t3_not_done", wb_valid, 1'b0);
    end
    beat_valid = 1'b0;
    chk("t3_wb_valid", wb_valid, 1'b1);
    chk("t3_data", wb_data, mk_vec(0));
    tick();
    chk("t3_done", busy, 1'b0);

    // Out-of-sequence beat while idle.
    set_beat(2, 600, 5'd1, 1'b1);
    tick();
    beat_valid = 1'b0;
    chk("t4_err_pulse", seq_err, 1'b1);
    chk("t4_idle", busy, 1'b0);
    chk("t4_ready", beat_ready, 1'b1);
    tick();
    chk("t4_err_clear", seq_err, 1'b0);
    chk("t4_still_idle", busy, 1'b0);
    chk("t4_data_kept", wb_data, mk_vec(0));

    // Vector with write enable low still completes the handshake.
    for (int k = 0; k < 5; k++) begin
      set_beat(k, 200, 5'd9, 1'b0);
      tick();
    end
    beat_valid = 1'b0;
    chk("t5_wb_valid", wb_valid, 1'b1);
    chk("t5_we", wb_we, 1'b0);
    chk("t5_addr", wb_addr, 5'd9);
    chk("t5_data", wb_data, mk_vec(200));
    tick();
    chk("t5_hs_valid", wb_valid, 1'b0);
    chk("t5_hs_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_writeback_collector.md
# vector_writeback_collector

Downstream neighbour of the execute stage. Receives the per-beat L-lane ALU results produced as the execute stage walks a V-element vector, reassembles them into a full V-element result, and presents one write to the vector register file through a valid/ready handshake. While the write is pending, the block back-pressures execute.

## Interface
- N, 32, element width in bits
- V, 20, elements per vector
- L, 4, lanes per beat; V % L != 0 is an elaboration error
- A, 5, register-file address width
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-low reset
- beat_valid_i  in  1  execute presents a beat
- beat_ready_o  out  1  collector can accept a beat
- beat_idx_i  in  $clog2(V/L)  beat number; element range idx*L .. idx*L+L-1
- beat_data_i  in  [L][N]  ALU results for lanes 0..L-1
- dest_addr_i  in  A  destination vector register; sampled on beat 0 only
- reg_write_i  in  1  write enable; sampled on beat 0 only
- wb_valid_o  out  1  full vector ready for register file
- wb_ready_i  in  1  register file accepts the write
- wb_addr_o  out  A  latched destination
- wb_we_o  out  1  latched write enable
- wb_data_o  out  [V][N]  assembled vector
- busy_o  out  1  state != IDLE
- seq_err_o  out  1  one-cycle pulse on an out-of-sequence beat

## Operation
- BEATS = V/L (5 at defaults). Beat counter `cnt` is $clog2(BEATS) wide.
- A beat is accepted on a rising edge where beat_valid_i && beat_ready_o.
- IDLE
  - beat_ready_o = 1.
  - Accepted beat with idx == 0: store lanes into elements 0..L-1, latch dest_addr_i and reg_write_i, set cnt = 1.
  - Next state is COLLECT, or WRITE if BEATS == 1.
- COLLECT
  - beat_ready_o = 1.
  - Accepted beat with idx == cnt: store lanes into elements cnt*L .. cnt*L+L-1, then cnt++.
  - If cnt was BEATS-1, next state is WRITE.
- Out-of-sequence beat, in IDLE (idx != 0) or COLLECT (idx != cnt):
  - The beat is consumed (ready stays 1).
  - Data is discarded.
  - seq_err_o pulses next cycle.
  - State, cnt and buffer are unchanged.
- WRITE
  - beat_ready_o = 0.
  - wb_valid_o = 1 and holds until wb_ready_i.
  - wb_addr_o, wb_we_o and wb_data_o are stable while wb_valid_o is high.
  - On handshake, next state is IDLE and cnt = 0.
- reg_write_i = 0 on beat 0: the vector is still collected and presented, with wb_we_o = 0. The handshake still completes.
- The buffer is not cleared between vectors. Each element is overwritten only by its own beat.
- Data path is a pure copy. No arithmetic and no width change: element j = beat_data_i[j % L] of beat j / L.

## Timing
- Reset (RST low, asynchronous):
  - State is IDLE and cnt = 0.
  - wb_valid_o = 0, wb_we_o = 0, wb_addr_o = 0, wb_data_o all zeros.
  - seq_err_o = 0, busy_o = 0, beat_ready_o = 1.
- Reset mid-collection or mid-WRITE discards the partial vector. No write is emitted.
- wb_valid_o rises on the cycle after the edge that accepts the last beat.
- Minimum spacing is BEATS+1 cycles per vector: BEATS accept cycles plus 1 WRITE cycle with wb_ready_i = 1.
- No bypass: in the cycle of the wb handshake, beat_ready_o is still 0. The next vector's beat 0 is accepted no earlier than the following cycle.
- beat_ready_o and busy_o are decoded from the registered state (Moore). They have no combinational path from beat_valid_i or wb_ready_i.
- seq_err_o is registered: high exactly one cycle, on the cycle after the offending beat.

## Structure
- Shared package vector_pkg holds:
  - N, V, L, A defaults
  - localparam BEATS = V/L
  - the state typedef `enum logic [1:0] {IDLE, COLLECT, WRITE}`
- The lane-slice arrays used by execute also live there.
- Single module with no sub-module. The buffer write is an indexed part-select by cnt.

## Test plan
- Reset, then drive beats idx 0..4 back-to-back, with beat k data = {4k+3, 4k+2, 4k+1, 4k}, dest 7, we 1, and wb_ready_i = 1.
  - wb_valid_o rises 1 cycle after beat 4.
  - wb_data_o[j] = j for j = 0..19, wb_addr_o = 7, wb_we_o = 1.
- Same stream with wb_ready_i held 0 for 6 cycles:
  - wb_valid_o holds and data stays stable.
  - beat_ready_o = 0 throughout.
  - A beat_valid_i held high is not accepted until the cycle after the handshake.
- Beats 0, 1, 3, 2, 3, 4:
  - seq_err_o pulses once, after the first idx 3.
  - The final wb_data_o matches the in-order result.
- Beat idx 2 while IDLE: seq_err_o pulses, state stays IDLE, busy_o = 0.
- Assert RST low after beat 2:
  - All outputs return to reset values.
  - A following full vector with dest 3 produces a single correct write to 3.
- Beat 0 with reg_write_i = 0 and dest 9: write is presented with wb_we_o = 0 and wb_addr_o = 9, and the handshake completes.
